shift_sequencer: RTL

- Iterative, area-reduced shift unit: applies one single-bit shift step per clock instead of an unrolled WIDTH-stage cascade.
- Operands are accepted with a start/ready handshake, then stepped `min(shamt, WIDTH)` times. The result is presented with a valid/ready handshake.
- Sits beside the ALU as the low-area shift option. It uses the same 2-bit operation encoding as the combinational shifter, so it drops in behind the same operation decode.

---
 rtl/shift_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Iterative shift unit: one single-bit step per clock, start/ready in, valid/ready out.
// Same 2-bit op encoding as the combinational shifter: SLL, SRL, SRA, pass.
module shift_sequencer #(
    parameter int WIDTH = 8,
    localparam int CNTW = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] shamt_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    localparam logic [WIDTH-1:0] W_AMT = WIDTH[WIDTH-1:0];
    localparam logic [CNTW-1:0]  W_CNT = WIDTH[CNTW-1:0];

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [CNTW-1:0]  n_c;
    logic [WIDTH-1:0] step_c;

    // Saturate the amount so latency never exceeds WIDTH steps.
    always_comb begin
        n_c = '0;
        if (sel_i != OP_PASS) begin
            if (shamt_i >= W_AMT) begin
                n_c = W_CNT;
            end else begin
                n_c = shamt_i[CNTW-1:0];
            end
        end
    end

    always_comb begin
        step_c = data_q;
        unique case (op_q)
            OP_SLL:  step_c = {data_q[WIDTH-2:0], 1'b0};
            OP_SRL:  step_c = {1'b0, data_q[WIDTH-1:1]};
            OP_SRA:  step_c = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            OP_PASS: step_c = data_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    data_d = A_i;
                    op_d   = sel_i;
                    if (n_c == '0) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = n_c;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                data_d = step_c;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNTW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            op_q    <= OP_SLL;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign busy_o  = (state_q == SHIFT);
    assign valid_o = (state_q == DONE);
    assign data_o  = valid_o ? data_q : '0;

endmodule
